// File: rtl/icache_responder_if.sv
// Instruction-fetch bus for icache_responder.
// Two sides are carried on one bundle:
//   datapath side : imemREN, imemaddr (requests) -> ihit, imemload (responses)
//   memory side   : iREN, iaddr (fill requests)  <- iwait, iload (fill responses)
// Modports:
//   slave  - the cache: takes datapath requests and memory responses,
//            drives datapath responses and memory requests.
//   master - the environment around it (datapath plus memory controller).
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits answer in the same cycle. A miss latches the word address, then runs a
// blocking fill over iREN/iaddr/iwait/iload. It returns to IDLE when the fill
// word lands, and the retried request hits on the following cycle.
// Ports:
//   CLK      - clock, all state on posedge
//   RST      - asynchronous active-high reset (clears frames, FSM, counters)
//   cif      - fetch bus (slave side): imemREN/imemaddr/ihit/imemload,
//              iREN/iaddr/iwait/iload
//   hit_cnt  - saturating count of cycles with ihit=1
//   miss_cnt - saturating count of misses started
module icache_responder #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  icache_responder_if.slave cif,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state_q, state_d;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      miss_addr_q;

  logic [31:0]      req_addr;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lookup_hit, served, miss_start, fill;

  // Byte offset is dropped here so that the latched fill address is word-aligned.
  assign req_addr   = cif.imemaddr & 32'hFFFF_FFFC;
  assign req_idx    = req_addr[IDX_W+1:2];
  assign req_tag    = req_addr[31:IDX_W+2];
  assign fill_idx   = miss_addr_q[IDX_W+1:2];
  assign lookup_hit = cif.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    served       = 1'b0;
    miss_start   = 1'b0;
    fill         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lookup_hit) begin
          cif.ihit     = 1'b1;
          cif.imemload = data_q[req_idx];
          served       = 1'b1;
        end else if (cif.imemREN) begin
          miss_start = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // The request in flight is the latched one; a redirected imemaddr
        // is looked up only after this fill completes.
        cif.iREN  = 1'b1;
        cif.iaddr = miss_addr_q;
        if (!cif.iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) miss_addr_q <= req_addr;
    end
  end

  // Frame storage. A fill simply overwrites the frame: the cache is read-only,
  // so there is never anything to write back on a conflict.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      // NOTE: the frames are small flop arrays rather than a RAM macro, so
      // clearing tags and data in reset costs nothing and keeps them defined.
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= miss_addr_q[31:IDX_W+2];
      data_q[fill_idx]  <= cif.iload;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (served && (hit_cnt != '1))      hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_start && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder.
// A second instance with 3-bit counters shares the same stimulus so that
// counter saturation is reached within a short run.
module tb_icache_responder;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_ren  = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        iwait     = 1'b1;

  logic [31:0] hit_cnt, miss_cnt;
  logic [2:0]  hit_cnt_s, miss_cnt_s;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  // Backing memory contents: word 0 holds the first instruction of the program.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h3C01_0001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  icache_responder_if cif ();
  icache_responder_if cif_s ();

  assign cif.imemREN    = imem_ren;
  assign cif.imemaddr   = imem_addr;
  assign cif.iwait      = iwait;
  assign cif.iload      = mem_word(cif.iaddr);
  assign cif_s.imemREN  = imem_ren;
  assign cif_s.imemaddr = imem_addr;
  assign cif_s.iwait    = iwait;
  assign cif_s.iload    = mem_word(cif_s.iaddr);

  icache_responder #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .cif(cif), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  icache_responder #(.SETS(16), .CNT_W(3)) dut_s (
    .CLK(CLK), .RST(RST), .cif(cif_s), .hit_cnt(hit_cnt_s), .miss_cnt(miss_cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  // ---------------- behavioural model ----------------
  // The cache is a table of 16 word addresses; a miss blocks the cache until
  // the memory drops iwait for the pending word.
  logic        m_valid [16];
  logic [31:0] m_word  [16];
  logic [31:0] m_data  [16];
  logic        m_busy;
  logic [31:0] m_pend;
  longint      m_hits, m_misses;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_word[i]  = '0;
      m_data[i]  = '0;
    end
    m_busy   = 1'b0;
    m_pend   = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial model_clear();

  // Compare process: outputs are checked mid-cycle, then the model advances
  // by the transfer that the coming posedge will perform.
  always @(negedge CLK) begin
    logic [31:0] wa;
    int          idx;
    if (RST) begin
      check("rst_ihit", cif.ihit, 0);
      check("rst_imemload", cif.imemload, 0);
      check("rst_iren", cif.iREN, 0);
      check("rst_iaddr", cif.iaddr, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      model_clear();
    end else begin
      check("hit_cnt", hit_cnt, sat(m_hits, 32));
      check("miss_cnt", miss_cnt, sat(m_misses, 32));
      check("hit_cnt_sat3", hit_cnt_s, sat(m_hits, 3));
      check("miss_cnt_sat3", miss_cnt_s, sat(m_misses, 3));
      if (m_busy) begin
        check("fetch_iren", cif.iREN, 1);
        check("fetch_iaddr", cif.iaddr, m_pend);
        check("fetch_ihit", cif.ihit, 0);
        check("fetch_imemload", cif.imemload, 0);
        if (!iwait) begin
          idx          = int'((m_pend >> 2) % 16);
          m_valid[idx] = 1'b1;
          m_word[idx]  = m_pend;
          m_data[idx]  = mem_word(m_pend);
          m_busy       = 1'b0;
        end
      end else begin
        check("idle_iren", cif.iREN, 0);
        wa  = imem_addr & 32'hFFFF_FFFC;
        idx = int'((wa >> 2) % 16);
        if (imem_ren && m_valid[idx] && m_word[idx] == wa) begin
          check("hit_ihit", cif.ihit, 1);
          check("hit_imemload", cif.imemload, m_data[idx]);
          m_hits++;
        end else begin
          check("nohit_ihit", cif.ihit, 0);
          check("nohit_imemload", cif.imemload, 0);
          if (imem_ren) begin
            m_busy = 1'b1;
            m_pend = wa;
            m_misses++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs a complete miss on address a with nwait busy cycles, ending in the
  // cycle where the retried request hits.
  task automatic miss_fill(input logic [31:0] a, input int nwait);
    imem_ren  = 1'b1;
    imem_addr = a;
    iwait     = 1'b1;
    #2;
    check("detect_ihit", cif.ihit, 0);
    check("detect_iren", cif.iREN, 0);
    step();
    for (int i = 0; i < nwait; i++) begin
      iwait = 1'b1;
      #2;
      check("busy_iren", cif.iREN, 1);
      check("busy_iaddr", cif.iaddr, a & 32'hFFFF_FFFC);
      step();
    end
    iwait = 1'b0;
    #2;
    check("fill_iren", cif.iREN, 1);
    check("fill_ihit", cif.ihit, 0);
    step();
    iwait = 1'b1;
    #2;
    check("after_fill_ihit", cif.ihit, 1);
    check("after_fill_data", cif.imemload, mem_word(a & 32'hFFFF_FFFC));
  endtask

  initial begin
    logic [31:0] a;

    // Reset state
    @(posedge CLK);
    #2;
    check("reset_ihit", cif.ihit, 0);
    check("reset_iren", cif.iREN, 0);
    check("reset_iaddr", cif.iaddr, 0);
    check("reset_miss_cnt", miss_cnt, 0);
    step();
    RST = 1'b0;

    // Cold miss on 0x0 with three busy cycles
    miss_fill(32'h0, 3);
    check("cold_data_literal", cif.imemload, 32'h3C01_0001);
    check("cold_miss_cnt", miss_cnt, 1);
    check("cold_hit_cnt", hit_cnt, 0);

    // Hits after the fill: this cycle plus four more
    for (int i = 0; i < 4; i++) begin
      step();
      #2;
      check("rehit_ihit", cif.ihit, 1);
      check("rehit_iren", cif.iREN, 0);
    end
    step();
    imem_ren = 1'b0;
    #2;
    check("rehit_hit_cnt", hit_cnt, 5);
    check("rehit_miss_cnt", miss_cnt, 1);

    // Conflict: 0x40 evicts 0x0, then 0x0 misses again (one-cycle fills)
    step();
    miss_fill(32'h40, 0);
    step();
    miss_fill(32'h0, 0);
    check("conflict_miss_cnt", miss_cnt, 3);
    check("conflict_hit_cnt", hit_cnt, 6);

    // Redirect during the fill of 0x10
    step();
    imem_ren  = 1'b1;
    imem_addr = 32'h10;
    iwait     = 1'b1;
    #2;
    check("redir_detect_ihit", cif.ihit, 0);
    step();
    imem_addr = 32'h80;
    #2;
    check("redir_iaddr0", cif.iaddr, 32'h10);
    step();
    #2;
    check("redir_iaddr1", cif.iaddr, 32'h10);
    step();
    iwait = 1'b0;
    #2;
    check("redir_fill_iaddr", cif.iaddr, 32'h10);
    step();
    iwait = 1'b1;
    #2;
    check("redir_new_miss_ihit", cif.ihit, 0);
    check("redir_new_miss_iren", cif.iREN, 0);
    step();
    iwait = 1'b0;
    #2;
    check("redir_new_iaddr", cif.iaddr, 32'h80);
    step();
    iwait = 1'b1;
    #2;
    check("redir_80_hit", cif.ihit, 1);
    check("redir_80_data", cif.imemload, mem_word(32'h80));
    step();
    imem_addr = 32'h10;
    #2;
    check("redir_10_hit", cif.ihit, 1);
    check("redir_10_data", cif.imemload, mem_word(32'h10));
    check("redir_miss_cnt", miss_cnt, 5);

    // Reset in the middle of a fill
    step();
    imem_addr = 32'h20;
    step();
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_iren", cif.iREN, 0);
    check("rst_mid_miss_cnt", miss_cnt, 0);
    step();
    RST = 1'b0;
    miss_fill(32'h0, 1);
    check("post_rst_miss_cnt", miss_cnt, 1);
    check("post_rst_hit_cnt", hit_cnt, 0);

    // Idle
    step();
    imem_ren = 1'b0;
    repeat (10) step();
    #2;
    check("idle_hit_cnt", hit_cnt, 1);
    check("idle_miss_cnt", miss_cnt, 1);
    check("idle_ihit", cif.ihit, 0);

    // Randomized traffic with sticky addresses so that retries hit
    a = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 9) < 4) begin
        a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a | 32'h8000_0000;
      end
      imem_addr = a;
      imem_ren  = ($urandom_range(0, 9) < 8);
      iwait     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        RST = 1'b1;
        step();
        RST = 1'b0;
      end
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
